// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - halfword-aligned fetch responder over a word-organised instruction SRAM
//
// Serves a 32-bit instruction window at a halfword-aligned fetch address.
// Windows that straddle a word boundary take two SRAM reads. A misaligned
// (odd) address returns an error response with no SRAM access. The program
// loader shares the single SRAM port, and a loader write wins over a fetch
// that is waiting in IDLE.
//
// Optional feature: define IMEM_WORD_CACHE_EN to add a one-entry word cache
// that lets a request skip the first SRAM read when its first word was the
// last word read.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   fetch_req/addr/flush fetch request, byte address, redirect abort
//   fetch_valid/data/err registered one-cycle response
//   ld_we/addr/wdata     loader write request
//   ld_ready             loader write accepted this cycle
//   mem_en/we/addr/wdata SRAM command (combinational from state and inputs)
//   mem_rdata            SRAM read data, one cycle after a read

module imem_fetch_responder #(
    parameter int          MEM_AW     = 12,
    parameter logic [31:0] RESET_DATA = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    input  logic              fetch_flush,
    output logic              fetch_valid,
    output logic [31:0]       fetch_data,
    output logic              fetch_err,
    input  logic              ld_we,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT0 = 2'd1,
        WAIT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] fetch_data_q, fetch_data_d;
    logic [15:0] lo_q, lo_d;

    logic [MEM_AW-1:0] wa0;
    logic [MEM_AW-1:0] wa1;
    logic              straddle;
    logic              misaligned;
    logic              cache_hit;
    logic [31:0]       cache_rdata;
    logic              unused_addr_hi;

    // fetch_addr is held stable for the whole request, so both word addresses
    // can be derived from it in every state instead of being registered.
    assign wa0        = fetch_addr[MEM_AW+1:2];
    assign wa1        = wa0 + MEM_AW'(1);   // last word wraps to word 0
    assign straddle   = fetch_addr[1];
    assign misaligned = fetch_addr[0];

    // Address bits above the SRAM range are ignored.
    assign unused_addr_hi = ^fetch_addr[31:MEM_AW+2];

`ifdef IMEM_WORD_CACHE_EN
    logic              cache_valid_q, cache_valid_d;
    logic [MEM_AW-1:0] cache_tag_q, cache_tag_d;
    logic [31:0]       cache_data_q, cache_data_d;

    // Every SRAM read that completes without a flush refills the entry. A
    // flushed read is discarded entirely, cache included. Loader writes only
    // happen in IDLE, so a fill and an invalidate never coincide.
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        if (state_q == WAIT0 && !fetch_flush) begin
            cache_valid_d = 1'b1;
            cache_tag_d   = wa0;
            cache_data_d  = mem_rdata;
        end else if (state_q == WAIT1 && !fetch_flush) begin
            cache_valid_d = 1'b1;
            cache_tag_d   = wa1;
            cache_data_d  = mem_rdata;
        end
        if (state_q == IDLE && ld_we && ld_addr == cache_tag_q) begin
            cache_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
        end
    end

    assign cache_hit   = cache_valid_q && (cache_tag_q == wa0);
    assign cache_rdata = cache_data_q;
`else
    assign cache_hit   = 1'b0;
    assign cache_rdata = '0;
`endif

    assign mem_wdata = ld_wdata;

    always_comb begin
        state_d       = state_q;
        fetch_valid_d = 1'b0;
        fetch_err_d   = 1'b0;
        fetch_data_d  = fetch_data_q;
        lo_d          = lo_q;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        ld_ready      = 1'b0;

        case (state_q)
            IDLE: begin
                if (ld_we) begin
                    // Loader write takes the port; a pending fetch retries next cycle.
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = ld_addr;
                    ld_ready = 1'b1;
                end else if (fetch_flush) begin
                    state_d = IDLE;
                end else if (fetch_req) begin
                    if (misaligned) begin
                        fetch_valid_d = 1'b1;
                        fetch_err_d   = 1'b1;
                        fetch_data_d  = RESET_DATA;
                        state_d       = RESP;
                    end else if (cache_hit && !straddle) begin
                        fetch_valid_d = 1'b1;
                        fetch_data_d  = cache_rdata;
                        state_d       = RESP;
                    end else if (cache_hit) begin
                        lo_d     = cache_rdata[31:16];
                        mem_en   = 1'b1;
                        mem_addr = wa1;
                        state_d  = WAIT1;
                    end else begin
                        mem_en   = 1'b1;
                        mem_addr = wa0;
                        state_d  = WAIT0;
                    end
                end
            end

            WAIT0: begin
                if (fetch_flush) begin
                    state_d = IDLE;
                end else if (straddle) begin
                    lo_d     = mem_rdata[31:16];
                    mem_en   = 1'b1;
                    mem_addr = wa1;
                    state_d  = WAIT1;
                end else begin
                    fetch_valid_d = 1'b1;
                    fetch_data_d  = mem_rdata;
                    state_d       = RESP;
                end
            end

            WAIT1: begin
                if (fetch_flush) begin
                    state_d = IDLE;
                end else begin
                    fetch_valid_d = 1'b1;
                    fetch_data_d  = {mem_rdata[15:0], lo_q};
                    state_d       = RESP;
                end
            end

            RESP: begin
                // The response is already on the outputs this cycle.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_data_q  <= RESET_DATA;
            lo_q          <= '0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_err_q   <= fetch_err_d;
            fetch_data_q  <= fetch_data_d;
            lo_q          <= lo_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_err   = fetch_err_q;
    assign fetch_data  = fetch_data_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - self-checking bench for imem_fetch_responder

module tb_imem_fetch_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_flush;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_err;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ready;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imem_fetch_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_flush(fetch_flush),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .fetch_err  (fetch_err),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_ready   (ld_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous-read SRAM model.
    logic [31:0] sram [0:4095];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_wdata = d;
        #1;
        if (!ld_ready) begin
            check("load_ready", {31'b0, ld_ready}, 32'd1);
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // Issues one fetch at a negedge (cycle 0) and watches up to 8 cycles.
    task automatic do_fetch(input logic [31:0] addr, output int lat, output logic [31:0] data,
                            output logic err, output int acc,
                            output logic [11:0] a0, output logic [11:0] a1);
        lat = -1; data = '0; err = 1'b0; acc = 0; a0 = '0; a1 = '0;
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = addr;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (mem_en) begin
                if (acc == 0) a0 = mem_addr;
                else if (acc == 1) a1 = mem_addr;
                acc++;
            end
            if (fetch_valid) begin
                lat = c; data = fetch_data; err = fetch_err;
                break;
            end
        end
        fetch_req = 1'b0;
    endtask

    typedef struct {
        logic [11:0] pa0;
        logic [31:0] pd0;
        logic [11:0] pa1;
        logic [31:0] pd1;
        logic [31:0] addr;
        logic [31:0] exp_data;
        int          exp_lat;
        logic        exp_err;
        int          exp_acc;
        logic [11:0] exp_a0;
        logic [11:0] exp_a1;
    } vec_t;

    vec_t vecs[8];

    int          lat, acc;
    logic [31:0] data;
    logic        err;
    logic [11:0] a0, a1;
    logic        seen;

    initial begin
        vecs[0] = '{12'd0,    32'h0041_0093, 12'd1, 32'hFFF0_8113, 32'h0000_0000, 32'h0041_0093, 2, 1'b0, 1, 12'd0,    12'd0};
        vecs[1] = '{12'd0,    32'h0041_0093, 12'd1, 32'hFFF0_8113, 32'h0000_0002, 32'h8113_0041, 3, 1'b0, 2, 12'd0,    12'd1};
        vecs[2] = '{12'd1,    32'hFFF0_8113, 12'd1, 32'hFFF0_8113, 32'h0000_0003, 32'h0000_0013, 1, 1'b1, 0, 12'd0,    12'd0};
        vecs[3] = '{12'd4095, 32'hAAAA_BBBB, 12'd0, 32'hCCCC_DDDD, 32'h0000_3FFE, 32'hDDDD_AAAA, 3, 1'b0, 2, 12'd4095, 12'd0};
        vecs[4] = '{12'd5,    32'h1234_5678, 12'd5, 32'h1234_5678, 32'h0000_0014, 32'h1234_5678, 2, 1'b0, 1, 12'd5,    12'd0};
        vecs[5] = '{12'd5,    32'h1234_5678, 12'd6, 32'h9ABC_DEF0, 32'h0000_0016, 32'hDEF0_1234, 3, 1'b0, 2, 12'd5,    12'd6};
        vecs[6] = '{12'd6,    32'h9ABC_DEF0, 12'd6, 32'h9ABC_DEF0, 32'h0000_0001, 32'h0000_0013, 1, 1'b1, 0, 12'd0,    12'd0};
        vecs[7] = '{12'd1,    32'h5566_7788, 12'd1, 32'h5566_7788, 32'h4000_0004, 32'h5566_7788, 2, 1'b0, 1, 12'd1,    12'd0};

        reset_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; fetch_flush = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_err",   {31'b0, fetch_err},   32'd0);
        check("rst_data",  fetch_data,           32'h0000_0013);
        check("rst_mem_en", {31'b0, mem_en},     32'd0);
        check("rst_mem_we", {31'b0, mem_we},     32'd0);
        check("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            load_word(vecs[i].pa0, vecs[i].pd0);
            load_word(vecs[i].pa1, vecs[i].pd1);
            do_fetch(vecs[i].addr, lat, data, err, acc, a0, a1);
            check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d_acc", i), acc, vecs[i].exp_acc);
            if (vecs[i].exp_acc >= 1) check($sformatf("v%0d_a0", i), {20'b0, a0}, {20'b0, vecs[i].exp_a0});
            if (vecs[i].exp_acc >= 2) check($sformatf("v%0d_a1", i), {20'b0, a1}, {20'b0, vecs[i].exp_a1});
        end

        // Flush in WAIT1 of a straddle fetch, then an aligned fetch.
        load_word(12'd8, 32'h1111_2222);
        load_word(12'd9, 32'h3333_4444);
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'h0000_0022;
        @(negedge clk);                               // WAIT0
        @(negedge clk);                               // WAIT1
        fetch_flush = 1'b1; fetch_req = 1'b0;
        #1;
        seen = fetch_valid;
        @(negedge clk);
        fetch_flush = 1'b0;
        #1;
        seen = seen | fetch_valid;
        check("flush_w1_no_valid", {31'b0, seen}, 32'd0);
        check("flush_w1_data_held", fetch_data, 32'h5566_7788);
        fetch_req = 1'b1; fetch_addr = 32'h0000_0024;  // issued in the cycle after the flush
        lat = -1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (fetch_valid) begin lat = c; data = fetch_data; break; end
        end
        fetch_req = 1'b0;
        check("after_flush_lat", lat, 2);
        check("after_flush_data", data, 32'h3333_4444);

        // Flush in WAIT0 of a straddle fetch must not issue the second read.
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'h0000_0022;
        @(negedge clk);
        fetch_flush = 1'b1; fetch_req = 1'b0;
        #1;
        check("flush_w0_no_read", {31'b0, mem_en}, 32'd0);
        @(negedge clk);
        fetch_flush = 1'b0;
        seen = 1'b0;
        repeat (3) begin #1 seen = seen | fetch_valid; @(negedge clk); end
        check("flush_w0_no_valid", {31'b0, seen}, 32'd0);

        // Asynchronous reset while a fetch is in WAIT0.
        fetch_req = 1'b1; fetch_addr = 32'h0000_0020;
        @(negedge clk);
        reset_n = 1'b0; fetch_req = 1'b0;
        #1;
        check("mid_rst_data", fetch_data, 32'h0000_0013);
        check("mid_rst_valid", {31'b0, fetch_valid}, 32'd0);
        check("mid_rst_mem_en", {31'b0, mem_en}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); #1 seen = seen | fetch_valid; end
        check("mid_rst_no_resp", {31'b0, seen}, 32'd0);

        // Loader write and fetch in the same cycle: write first, then read back.
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 12'd7; ld_wdata = 32'hCAFE_BABE;
        fetch_req = 1'b1; fetch_addr = 32'h0000_001C;
        #1;
        check("ldf_ready", {31'b0, ld_ready}, 32'd1);
        check("ldf_we", {31'b0, mem_we}, 32'd1);
        check("ldf_waddr", {20'b0, mem_addr}, 32'd7);
        @(negedge clk);
        ld_we = 1'b0;
        #1;
        check("ldf_rd", {30'b0, mem_en, mem_we}, 32'b10);
        check("ldf_ready_low", {31'b0, ld_ready}, 32'd0);
        lat = -1;
        for (int c = 2; c < 9; c++) begin
            @(negedge clk);
            #1;
            if (fetch_valid) begin lat = c; data = fetch_data; break; end
        end
        fetch_req = 1'b0;
        check("ldf_lat", lat, 3);
        check("ldf_data", data, 32'hCAFE_BABE);

`ifdef IMEM_WORD_CACHE_EN
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        load_word(12'd0, 32'h0041_0093);
        load_word(12'd1, 32'hFFF0_8113);
        do_fetch(32'h0, lat, data, err, acc, a0, a1);
        check("c_miss_lat", lat, 2);
        do_fetch(32'h0, lat, data, err, acc, a0, a1);
        check("c_hit_lat", lat, 1);
        check("c_hit_acc", acc, 0);
        check("c_hit_data", data, 32'h0041_0093);
        load_word(12'd0, 32'h0000_0297);
        do_fetch(32'h0, lat, data, err, acc, a0, a1);
        check("c_inv_lat", lat, 2);
        check("c_inv_data", data, 32'h0000_0297);
        do_fetch(32'h2, lat, data, err, acc, a0, a1);
        check("c_str_lat", lat, 2);
        check("c_str_acc", acc, 1);
        check("c_str_a0", {20'b0, a0}, 32'd1);
        check("c_str_data", data, 32'h8113_0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
